// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Brief    : Round-robin, burst-limited arbiter sharing one synchronous data
//            memory between the CPU port (0) and the raycast fetch port (1).
//            Optional stall counters enabled by defining ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_0,
    input  logic                  we_0,
    input  logic [ADDR_WIDTH-1:0] addr_0,
    input  logic [DATA_WIDTH-1:0] wdata_0,
    input  logic                  req_1,
    input  logic                  we_1,
    input  logic [ADDR_WIDTH-1:0] addr_1,
    input  logic [DATA_WIDTH-1:0] wdata_1,
    output logic                  grant_0,
    output logic                  grant_1,
    output logic                  rvalid_0,
    output logic                  rvalid_1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  memory_write_enable,
    output logic [ADDR_WIDTH-1:0] memory_address,
    output logic [DATA_WIDTH-1:0] memory_write_data,
`ifdef ARB_STATS_EN
    output logic [15:0]           stall_count_0,
    output logic [15:0]           stall_count_1,
`endif
    input  logic [DATA_WIDTH-1:0] memory_read_data
);

    localparam int              c_CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_ONE = c_CNT_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_burst_count;
    logic [c_CNT_W-1:0] w_burst_next;
    logic               r_last;
    logic               w_last_next;
    logic               r_rvalid_0;
    logic               r_rvalid_1;
    logic               w_grant_0;
    logic               w_grant_1;
    logic               w_burst_full;

    assign w_burst_full = (r_burst_count == c_MAX);

    // Winner selection; the owner keeps the memory until it has used a full
    // burst while the other side is waiting.
    always_comb begin
        w_grant_0 = 1'b0;
        w_grant_1 = 1'b0;
        if (!reset) begin
            case (r_state)
                S_OWN0: begin
                    if (req_0 && !(req_1 && w_burst_full)) w_grant_0 = 1'b1;
                    else if (req_1)                        w_grant_1 = 1'b1;
                end
                S_OWN1: begin
                    if (req_1 && !(req_0 && w_burst_full)) w_grant_1 = 1'b1;
                    else if (req_0)                        w_grant_0 = 1'b1;
                end
                default: begin
                    if (req_0 && req_1) begin
                        w_grant_0 = r_last;
                        w_grant_1 = !r_last;
                    end else begin
                        w_grant_0 = req_0;
                        w_grant_1 = req_1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_state_next = S_IDLE;
        w_burst_next = '0;
        w_last_next  = r_last;
        if (w_grant_0 || w_grant_1) begin
            w_state_next = w_grant_0 ? S_OWN0 : S_OWN1;
            w_last_next  = w_grant_1;
            if (r_state != w_state_next) w_burst_next = c_ONE;
            else if (w_burst_full)       w_burst_next = c_MAX;
            else                         w_burst_next = r_burst_count + c_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_burst_count <= '0;
            r_last        <= 1'b1;
            r_rvalid_0    <= 1'b0;
            r_rvalid_1    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_burst_count <= w_burst_next;
            r_last        <= w_last_next;
            r_rvalid_0    <= w_grant_0 & ~we_0;
            r_rvalid_1    <= w_grant_1 & ~we_1;
        end
    end

    always_comb begin
        grant_0             = w_grant_0;
        grant_1             = w_grant_1;
        rvalid_0            = r_rvalid_0;
        rvalid_1            = r_rvalid_1;
        rdata               = memory_read_data;
        memory_write_enable = 1'b0;
        memory_address      = '0;
        memory_write_data   = '0;
        if (w_grant_0) begin
            memory_write_enable = we_0;
            memory_address      = addr_0;
            memory_write_data   = wdata_0;
        end else if (w_grant_1) begin
            memory_write_enable = we_1;
            memory_address      = addr_1;
            memory_write_data   = wdata_1;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_stall_0;
    logic [15:0] r_stall_1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_0 <= '0;
            r_stall_1 <= '0;
        end else begin
            if (req_0 && !w_grant_0 && r_stall_0 != 16'hFFFF) r_stall_0 <= r_stall_0 + 16'd1;
            if (req_1 && !w_grant_1 && r_stall_1 != 16'hFFFF) r_stall_1 <= r_stall_1 + 16'd1;
        end
    end

    assign stall_count_0 = r_stall_0;
    assign stall_count_1 = r_stall_1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Brief    : Scoreboard bench for memory_arbiter with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_0, we_0, req_1, we_1;
    logic [15:0] addr_0, wdata_0, addr_1, wdata_1;
    logic        grant_0, grant_1, rvalid_0, rvalid_1;
    logic [15:0] rdata;
    logic        memory_write_enable;
    logic [15:0] memory_address, memory_write_data, memory_read_data;
`ifdef ARB_STATS_EN
    logic [15:0] stall_count_0, stall_count_1;
`endif

    always #5 clock = ~clock;

    memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .MAX_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .grant_0(grant_0), .grant_1(grant_1),
        .rvalid_0(rvalid_0), .rvalid_1(rvalid_1), .rdata(rdata),
        .memory_write_enable(memory_write_enable),
        .memory_address(memory_address),
        .memory_write_data(memory_write_data),
`ifdef ARB_STATS_EN
        .stall_count_0(stall_count_0), .stall_count_1(stall_count_1),
`endif
        .memory_read_data(memory_read_data)
    );

    logic [15:0] mem [0:65535];

    always @(posedge clock) begin
        if (memory_write_enable) mem[memory_address] <= memory_write_data;
        memory_read_data <= mem[memory_address];
    end

    typedef struct {
        int          slot;
        bit          port;
        logic [15:0] data;
    } rd_t;

    rd_t q[$];
    int  slot = 0;
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (slot %0d)", tag, got, exp, slot);
        end
    endtask

    // One clock cycle: check grants/memory bus at negedge, retire expected
    // read returns, then queue the reads issued this cycle.
    task automatic step(input bit e0, input bit e1);
        logic        ewe;
        logic [15:0] eaddr, ewd;
        rd_t         r;
        @(negedge clock);
        chk("grant_0", 32'(grant_0), 32'(e0));
        chk("grant_1", 32'(grant_1), 32'(e1));
        ewe = 1'b0; eaddr = '0; ewd = '0;
        if (e0)      begin ewe = we_0; eaddr = addr_0; ewd = wdata_0; end
        else if (e1) begin ewe = we_1; eaddr = addr_1; ewd = wdata_1; end
        chk("mem_we",    32'(memory_write_enable), 32'(ewe));
        chk("mem_addr",  32'(memory_address),      32'(eaddr));
        chk("mem_wdata", 32'(memory_write_data),   32'(ewd));
        if (q.size() > 0 && q[0].slot == slot) begin
            r = q.pop_front();
            chk("rvalid_0", 32'(rvalid_0), 32'(r.port == 1'b0));
            chk("rvalid_1", 32'(rvalid_1), 32'(r.port == 1'b1));
            chk("rdata",    32'(rdata),    32'(r.data));
        end else begin
            chk("rvalid_0_idle", 32'(rvalid_0), 32'd0);
            chk("rvalid_1_idle", 32'(rvalid_1), 32'd0);
        end
        if (e0 && !we_0) q.push_back('{slot + 1, 1'b0, mem[addr_0]});
        if (e1 && !we_1) q.push_back('{slot + 1, 1'b1, mem[addr_1]});
        slot++;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit r0, input bit w0, input logic [15:0] a0,
                         input bit r1, input bit w1, input logic [15:0] a1);
        req_0 = r0; we_0 = w0; addr_0 = a0;
        req_1 = r1; we_1 = w1; addr_1 = a1;
    endtask

    logic [9:0] c_both_order;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        wdata_0 = 16'h0F0F;
        wdata_1 = 16'h0000;
        reset = 1'b1;
        drive(1, 0, 16'h0040, 0, 0, 16'h0000);
        step(0, 0);
        step(0, 0);
`ifdef ARB_STATS_EN
        chk("stall_0_reset", 32'(stall_count_0), 32'd0);
        chk("stall_1_reset", 32'(stall_count_1), 32'd0);
`endif
        reset = 1'b0;

        // single read on port 0
        drive(1, 0, 16'h0010, 0, 0, 16'h0000);
        step(1, 0);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        step(0, 0);

        // contention from IDLE straight out of reset
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
        c_both_order = 10'b0011110000;
        drive(1, 0, 16'h0100, 1, 0, 16'h0200);
        for (int i = 0; i < 10; i++) step(!c_both_order[i], c_both_order[i]);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        step(0, 0);

        // port 1 write
        wdata_1 = 16'hBEEF;
        drive(0, 0, 16'h0000, 1, 1, 16'h1234);
        step(0, 1);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        step(0, 0);
        chk("mem_1234", 32'(mem[16'h1234]), 32'h0000BEEF);

        // port 1 streams alone, then port 0 arrives after the burst saturated
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 16'h0000, 1, 0, 16'h2000 + 16'(i));
            step(0, 1);
        end
        drive(1, 0, 16'h0300, 1, 0, 16'h200A);
        step(1, 0);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        step(0, 0);

        // reset right after a port-0 read grant
        drive(1, 0, 16'h0010, 0, 0, 16'h0000);
        step(1, 0);
        reset = 1'b1;
        step(0, 0);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        step(0, 0);
        reset = 1'b0;
        drive(1, 0, 16'h0020, 1, 0, 16'h0030);
        step(1, 0);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        step(0, 0);

`ifdef ARB_STATS_EN
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
        drive(1, 0, 16'h0400, 1, 0, 16'h0500);
        for (int i = 0; i < 4; i++) step(1, 0);
        drive(0, 0, 16'h0000, 1, 0, 16'h0500);
        step(0, 1);
        chk("stall_count_1", 32'(stall_count_1), 32'd4);
        chk("stall_count_0", 32'(stall_count_0), 32'd0);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        step(0, 0);
`endif

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
